uchar_to_float: RTL and testbench
=================================

Name: uchar_to_float

Overview:
- Converts an 8-bit unsigned integer (0..255) to an IEEE-754 single-precision value, presented as separate sign, exponent and fraction fields.
- Used in the character-recognition datapath to turn raw pixel bytes into float operands for downstream float arithmetic.
- Single-cycle registered stage with a simple valid qualifier.

Parameters:
- EXP_BIAS, 127, exponent bias added to the leading-one bit position (fixed at 127 for IEEE-754 single).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  D is valid this cycle.
- D  input  8  unsigned integer to convert.
- out_valid  output  1  S/E/F hold a new result.
- S  output  1  float sign bit (float[31]).
- E  output  8  biased exponent (float[30:23]).
- F  output  23  fraction / mantissa without the hidden bit (float[22:0]).

Behaviour:
- Reset: on a rising clk edge with rst_n=0, S=0, E=0, F=0 and out_valid=0. Reset has priority over in_valid. A conversion in flight is discarded.
- Latency: exactly 1 cycle. D sampled with in_valid=1 at edge N appears on S/E/F at edge N with out_valid=1. Full throughput: one conversion per cycle, no backpressure.
- When in_valid=0: out_valid=0 next cycle. S/E/F hold their previous values (no update).
- Conversion is combinational from D and registered at the output:
  - S is always 0, since the input is unsigned.
  - D=0: E=0, F=0 (positive zero, 0x00000000).
  - D≠0: p = index of the most significant 1 bit (0..7), found by a priority encoder.
  - E = EXP_BIAS + p, giving a range of 127..134.
  - F = the bits of D below the leading one, left-aligned into F[22:0]. That is, F = (D << (23−p)) truncated to 23 bits. F[15:0] is always 0.
- Conversion is exact for all 256 inputs: no rounding, no denormals, no infinities or NaN.
- Output word {S,E,F} must equal the IEEE-754 encoding of the real value D for every D.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, D=8'd5 -> S/E/F all 0, out_valid=0. After release, the first valid D is converted normally.
- Small sequence: D=0,1,2,3,...,11 on consecutive cycles with in_valid=1 -> one cycle later, in order:
  - 0x00000000, 0x3F800000, 0x40000000, 0x40400000
  - 0x40800000, 0x40A00000, 0x40C00000, 0x40E00000
  - 0x41000000, 0x41100000, 0x41200000, 0x41300000
  - out_valid=1 throughout.
- Boundaries:
  - D=128 -> E=134, F=0 (0x43000000).
  - D=255 -> E=134, F=0x7F0000 (0x437F0000).
  - D=127 -> E=133, F=0x7E0000 (0x42FE0000).
- Powers of two: D=1,2,4,...,128 -> F=0, E=127..134 in steps of 1.
- Valid gating: in_valid=0 with D changing -> out_valid=0 and S/E/F unchanged from the last valid result.
- Exhaustive sweep: all 256 D values -> {S,E,F} matches a reference real-to-float conversion, S always 0.

Source files
------------

// File: rtl/uchar_to_float.sv
// uchar_to_float
// Converts an unsigned byte to an IEEE-754 single-precision value. The value
// is split into sign, biased exponent and fraction fields. There is one
// registered stage, and a valid bit travels alongside the data.
// Every input in 0..255 is exact in single precision, so no rounding is needed.
module uchar_to_float #(
    parameter int unsigned EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  D,
    output logic        out_valid,
    output logic        S,
    output logic [7:0]  E,
    output logic [22:0] F
);

    localparam logic [7:0] BIAS8 = 8'(EXP_BIAS);

    logic [2:0]  msb_pos;
    logic        nonzero;
    logic [31:0] shifted;
    logic [7:0]  e_next;
    logic [22:0] f_next;

    // Priority encoder: the highest set bit of D wins.
    always_comb begin
        msb_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (D[i]) begin
                msb_pos = i[2:0];
            end
        end
    end

    assign nonzero = |D;

    // Shift left so the leading one lands at bit 23.
    // Truncating to 23 bits then drops the hidden bit.
    // The bits below the leading one end up left-aligned in the fraction.
    always_comb begin
        shifted = {24'd0, D} << (5'd23 - {2'b00, msb_pos});
        e_next  = 8'd0;
        f_next  = 23'd0;
        if (nonzero) begin
            e_next = BIAS8 + {5'd0, msb_pos};
            f_next = shifted[22:0];
        end
    end

    // Output register.
    // Reset clears everything, including a conversion in flight.
    // The result fields only load on a valid input.
    // When the input is not valid they keep their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= 1'b0;
            E         <= 8'd0;
            F         <= 23'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S <= 1'b0;
                E <= e_next;
                F <= f_next;
            end
        end
    end

endmodule

// File: tb/tb_uchar_to_float.sv
// Directed bench for uchar_to_float.
// The expected words are hand-written IEEE-754 constants.
// The sweep reference is derived from the double-precision encoding of the value.
module tb_uchar_to_float;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  D;
    logic        out_valid;
    logic        S;
    logic [7:0]  E;
    logic [22:0] F;

    int checks = 0;
    int passed = 0;

    uchar_to_float dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .D         (D),
        .out_valid (out_valid),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word();
        return {S, E, F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        D        = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_float(input int unsigned v);
        logic [63:0] b;
        logic [10:0] e11;
        if (v == 0) return 32'h0;
        b   = $realtobits(real'(v));
        e11 = b[62:52] - 11'd896;
        return {1'b0, e11[7:0], b[51:29]};
    endfunction

    logic [31:0] seq_exp [12] = '{
        32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
        32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000
    };
    logic [31:0] pow_exp [8] = '{
        32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000,
        32'h41800000, 32'h42000000, 32'h42800000, 32'h43000000
    };

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        D        = 8'd5;

        // Reset has priority over a valid input.
        step(1'b1, 8'd5);
        check("rst_word_c1", word(), 32'h0);
        check("rst_valid_c1", {31'd0, out_valid}, 32'd0);
        step(1'b1, 8'd5);
        check("rst_word_c2", word(), 32'h0);
        check("rst_valid_c2", {31'd0, out_valid}, 32'd0);

        // After release, the first valid input converts normally.
        rst_n = 1'b1;
        step(1'b1, 8'd5);
        check("first_after_rst", word(), 32'h40A00000);
        check("first_valid", {31'd0, out_valid}, 32'd1);

        // Back-to-back sequence of 0 through 11.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'(i));
            check($sformatf("seq_%0d", i), word(), seq_exp[i]);
            check($sformatf("seq_valid_%0d", i), {31'd0, out_valid}, 32'd1);
        end

        // Boundary values.
        step(1'b1, 8'd128);
        check("d128", word(), 32'h43000000);
        step(1'b1, 8'd255);
        check("d255", word(), 32'h437F0000);
        step(1'b1, 8'd127);
        check("d127", word(), 32'h42FE0000);

        // Powers of two.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'd1 << i);
            check($sformatf("pow2_%0d", i), word(), pow_exp[i]);
        end

        // Valid gating: the fields hold the last result, 128.
        step(1'b0, 8'd77);
        check("gate_valid_a", {31'd0, out_valid}, 32'd0);
        check("gate_hold_a", word(), 32'h43000000);
        step(1'b0, 8'd200);
        check("gate_valid_b", {31'd0, out_valid}, 32'd0);
        check("gate_hold_b", word(), 32'h43000000);
        step(1'b1, 8'd200);
        check("gate_resume", word(), 32'h43480000);

        // Reset discards a conversion in flight.
        rst_n = 1'b0;
        step(1'b1, 8'd9);
        check("rst_inflight", word(), 32'h0);
        check("rst_inflight_v", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // Exhaustive sweep against the real-valued reference.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'(i));
            check($sformatf("sweep_%0d", i), word(), ref_float(i));
            check($sformatf("sweep_v_%0d", i), {31'd0, out_valid}, 32'd1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
